// File: rtl/adc_promediador_pkg.sv
// -----------------------------------------------------------------------------
// adc_promediador_pkg
// Shared definitions for the ADC averaging path.
//   ADC_DATA_W  : default conversion width, shared with the receiver and formatter
//   ADC_LOG2_N  : default log2 of the averaging window length
//   adc_state_t : state encoding of the averaging controller
// -----------------------------------------------------------------------------
package adc_promediador_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_LOG2_N = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_TMR = 3'd1,
        REQUEST  = 3'd2,
        ACCUM    = 3'd3,
        PUBLISH  = 3'd4
    } adc_state_t;

endpackage

// File: rtl/adc_promediador_ventana_stats.sv
// -----------------------------------------------------------------------------
// adc_ventana_stats
// Window statistics: sum, sample count, running minimum and maximum.
// Ports:
//   clk_nexys   in   system clock
//   reset       in   asynchronous, active-low reset
//   i_clear     in   empty the window (has priority over i_load)
//   i_load      in   add i_sample to the window
//   i_sample    in   sample to add
//   o_last      out  window already holds 2^LOG2_N-1 samples, next load fills it
//   o_avg_upd   out  average of the window including i_sample
//   o_min_upd   out  minimum of the window including i_sample
//   o_max_upd   out  maximum of the window including i_sample
// The *_upd outputs let the caller publish on the same edge that adds the
// final sample, without waiting for the registers to settle.
// -----------------------------------------------------------------------------
module adc_ventana_stats
    import adc_promediador_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int LOG2_N = ADC_LOG2_N
) (
    input  logic              clk_nexys,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_last,
    output logic [DATA_W-1:0] o_avg_upd,
    output logic [DATA_W-1:0] o_min_upd,
    output logic [DATA_W-1:0] o_max_upd
);

    // LOG2_N extra bits hold 2^LOG2_N full-scale samples without overflow.
    localparam int ACC_W = DATA_W + LOG2_N;

    logic [ACC_W-1:0]  r_acc;
    logic [LOG2_N-1:0] r_count;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    logic [ACC_W-1:0]  w_acc_upd;
    logic [DATA_W-1:0] w_min_upd;
    logic [DATA_W-1:0] w_max_upd;

    always_comb begin
        w_acc_upd = r_acc + ACC_W'(i_sample);
        w_min_upd = (i_sample < r_min) ? i_sample : r_min;
        w_max_upd = (i_sample > r_max) ? i_sample : r_max;
    end

    assign o_last    = &r_count;
    assign o_avg_upd = w_acc_upd[ACC_W-1:LOG2_N];   // truncating divide
    assign o_min_upd = w_min_upd;
    assign o_max_upd = w_max_upd;

    always_ff @(posedge clk_nexys or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_min   <= '1;
            r_max   <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_count <= '0;
            r_min   <= '1;
            r_max   <= '0;
        end else if (i_load) begin
            r_acc   <= w_acc_upd;
            r_count <= r_count + 1'b1;   // wraps to 0 on the window's last sample
            r_min   <= w_min_upd;
            r_max   <= w_max_upd;
        end
    end

endmodule

// File: rtl/adc_promediador.sv
// -----------------------------------------------------------------------------
// adc_promediador
// Paces the serial ADC receiver with a fixed sample timer and publishes the
// average, minimum and maximum of every 2^LOG2_N accepted conversions.
// Ports:
//   clk_nexys    in   system clock
//   reset        in   asynchronous, active-low reset
//   enable       in   run; low returns to IDLE and discards the partial window
//   rx_done_tick in   one-cycle strobe from receiver, data_in valid
//   data_in      in   conversion result from receiver
//   rx_en        out  conversion request to receiver (level)
//   avg_out      out  last window average
//   min_out      out  last window minimum
//   max_out      out  last window maximum
//   avg_valid    out  one-cycle strobe, new window results
//   timeout_err  out  sticky, receiver failed to answer a request
// -----------------------------------------------------------------------------
module adc_promediador
    import adc_promediador_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_N     = ADC_LOG2_N,
    parameter int SAMPLE_DIV = 5000,
    parameter int TIMEOUT    = 2000
) (
    input  logic              clk_nexys,
    input  logic              reset,
    input  logic              enable,
    input  logic              rx_done_tick,
    input  logic [DATA_W-1:0] data_in,
    output logic              rx_en,
    output logic [DATA_W-1:0] avg_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic              avg_valid,
    output logic              timeout_err
);

    localparam int TMR_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

    adc_state_t        r_state;
    adc_state_t        w_state_next;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_next;
    logic [WD_W-1:0]   r_wdog;
    logic [WD_W-1:0]   w_wdog_next;
    logic [DATA_W-1:0] r_sample;
    logic              r_rx_en;
    logic              r_avg_valid;
    logic              r_timeout_err;
    logic [DATA_W-1:0] r_avg_out;
    logic [DATA_W-1:0] r_min_out;
    logic [DATA_W-1:0] r_max_out;

    logic              w_clear;
    logic              w_load;
    logic              w_capture;
    logic              w_set_err;
    logic              w_publish;
    logic              w_last;
    logic [DATA_W-1:0] w_avg_upd;
    logic [DATA_W-1:0] w_min_upd;
    logic [DATA_W-1:0] w_max_upd;

    adc_ventana_stats #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_stats (
        .clk_nexys (clk_nexys),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_load    (w_load),
        .i_sample  (r_sample),
        .o_last    (w_last),
        .o_avg_upd (w_avg_upd),
        .o_min_upd (w_min_upd),
        .o_max_upd (w_max_upd)
    );

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_wdog_next  = '0;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_set_err    = 1'b0;
        w_publish    = 1'b0;

        if (!enable) begin
            w_state_next = IDLE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_timer_next = TMR_RELOAD;
                    w_clear      = 1'b1;
                    w_state_next = WAIT_TMR;
                end
                WAIT_TMR: begin
                    if (r_timer == '0) begin
                        w_state_next = REQUEST;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                REQUEST: begin
                    // A sample arriving in the expiry cycle still counts.
                    if (rx_done_tick) begin
                        w_capture    = 1'b1;
                        w_state_next = ACCUM;
                    end else if (r_wdog == WD_LAST) begin
                        w_set_err    = 1'b1;
                        w_clear      = 1'b1;
                        w_timer_next = TMR_RELOAD;
                        w_state_next = WAIT_TMR;
                    end else begin
                        w_wdog_next = r_wdog + 1'b1;
                    end
                end
                ACCUM: begin
                    w_load = 1'b1;
                    if (w_last) begin
                        w_publish    = 1'b1;
                        w_state_next = PUBLISH;
                    end else begin
                        w_timer_next = TMR_RELOAD;
                        w_state_next = WAIT_TMR;
                    end
                end
                PUBLISH: begin
                    w_clear      = 1'b1;
                    w_timer_next = TMR_RELOAD;
                    w_state_next = WAIT_TMR;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_nexys or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_wdog        <= '0;
            r_sample      <= '0;
            r_rx_en       <= 1'b0;
            r_avg_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_avg_out     <= '0;
            r_min_out     <= '0;
            r_max_out     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_wdog      <= w_wdog_next;
            // Registered so the request line is glitch-free toward the receiver.
            r_rx_en     <= (w_state_next == REQUEST);
            r_avg_valid <= w_publish;
            if (w_capture) begin
                r_sample <= data_in;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
            // Results land on the edge entering PUBLISH, together with avg_valid.
            if (w_publish) begin
                r_avg_out <= w_avg_upd;
                r_min_out <= w_min_upd;
                r_max_out <= w_max_upd;
            end
        end
    end

    assign rx_en       = r_rx_en;
    assign avg_valid   = r_avg_valid;
    assign timeout_err = r_timeout_err;
    assign avg_out     = r_avg_out;
    assign min_out     = r_min_out;
    assign max_out     = r_max_out;

endmodule

// File: tb/tb_adc_promediador.sv
module tb_adc_promediador;

    localparam int DW   = 12;
    localparam int N    = 16;
    localparam int SDIV = 6;
    localparam int TOUT = 10;

    logic          clk_nexys;
    logic          reset;
    logic          enable;
    logic          rx_done_tick;
    logic [DW-1:0] data_in;
    logic          rx_en;
    logic [DW-1:0] avg_out;
    logic [DW-1:0] min_out;
    logic [DW-1:0] max_out;
    logic          avg_valid;
    logic          timeout_err;

    adc_promediador #(
        .DATA_W     (DW),
        .LOG2_N     (4),
        .SAMPLE_DIV (SDIV),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk_nexys    (clk_nexys),
        .reset        (reset),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .data_in      (data_in),
        .rx_en        (rx_en),
        .avg_out      (avg_out),
        .min_out      (min_out),
        .max_out      (max_out),
        .avg_valid    (avg_valid),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk_nexys = 1'b0;
        forever #5 clk_nexys = ~clk_nexys;
    end

    typedef struct {
        logic [DW-1:0] avg;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
    } exp_t;

    typedef struct {
        string         name;
        logic [DW-1:0] first;
        int            step;
        int            lat;
        logic [DW-1:0] e_avg;
        logic [DW-1:0] e_min;
        logic [DW-1:0] e_max;
    } vec_t;

    logic [DW-1:0] samp_q[$];
    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            windows = 0;
    logic          prev_valid = 1'b0;
    logic          resp_on = 1'b1;
    logic          spur_on = 1'b0;
    int            resp_lat = 0;

    // Receiver model: answers a request after resp_lat extra cycles using the
    // next queued sample; optionally injects strobes while not requested.
    initial begin
        int  lat_cnt;
        logic tgl;
        lat_cnt = 0;
        tgl = 1'b0;
        rx_done_tick = 1'b0;
        data_in = '0;
        forever begin
            @(negedge clk_nexys);
            rx_done_tick = 1'b0;
            if (rx_en && resp_on && samp_q.size() > 0) begin
                if (lat_cnt >= resp_lat) begin
                    rx_done_tick = 1'b1;
                    data_in = samp_q.pop_front();
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
                if (spur_on && !rx_en) begin
                    tgl = ~tgl;
                    if (tgl) begin
                        rx_done_tick = 1'b1;
                        data_in = 12'hFFF;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // One clock step; every published window is checked against the scoreboard.
    task automatic cyc();
        exp_t e;
        @(negedge clk_nexys);
        if (avg_valid) begin
            windows++;
            total++;
            if (prev_valid) begin
                bad++;
                $display("FAIL valid_width: got 2+ cycles required 1");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got avg=%0h required no strobe", avg_out);
            end else begin
                total--;
                e = exp_q.pop_front();
                $display("window %0d: avg=%03h min=%03h max=%03h", windows, avg_out, min_out, max_out);
                chk("win_avg", 32'(avg_out), 32'(e.avg));
                chk("win_min", 32'(min_out), 32'(e.mn));
                chk("win_max", 32'(max_out), 32'(e.mx));
            end
        end
        prev_valid = avg_valid;
    endtask

    task automatic queue_model(input logic [DW-1:0] v, input int cnt, input logic push_exp);
        int   sum;
        exp_t e;
        sum = 0;
        e.mn = '1;
        e.mx = '0;
        for (int i = 0; i < cnt; i++) begin
            samp_q.push_back(v);
            sum += int'(v);
            if (v < e.mn) e.mn = v;
            if (v > e.mx) e.mx = v;
        end
        e.avg = DW'(sum / N);
        if (push_exp) exp_q.push_back(e);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d windows pending required 0", nm, exp_q.size());
            exp_q.delete();
            samp_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        int   vcount;
        exp_t e;

        vecs[0] = '{"const800",  12'h800, 0,   0, 12'h800, 12'h800, 12'h800};
        vecs[1] = '{"ramp",      12'h000, 1,   1, 12'h007, 12'h000, 12'h00F};
        vecs[2] = '{"allfff",    12'hFFF, 0,   2, 12'hFFF, 12'hFFF, 12'hFFF};
        vecs[3] = '{"ramp_desc", 12'hF00, -16, 3, 12'hE88, 12'hE10, 12'hF00};
        vecs[4] = '{"lat_edge",  12'h100, 16,  TOUT - 1, 12'h178, 12'h100, 12'h1F0};

        reset = 1'b0;
        enable = 1'b0;
        idle_cycles(3);
        chk("rst_rx_en", 32'(rx_en), 0);
        chk("rst_avg", 32'(avg_out), 0);
        chk("rst_min", 32'(min_out), 0);
        chk("rst_max", 32'(max_out), 0);
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_err", 32'(timeout_err), 0);
        reset = 1'b1;
        idle_cycles(2);

        // Table-driven windows; the last one answers in the watchdog's final cycle.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) samp_q.push_back(DW'(int'(vecs[v].first) + i * vecs[v].step));
            e.avg = vecs[v].e_avg;
            e.mn  = vecs[v].e_min;
            e.mx  = vecs[v].e_max;
            exp_q.push_back(e);
            resp_lat = vecs[v].lat;
            enable = 1'b1;
            wait_done(vecs[v].name, 800);
            enable = 1'b0;
            idle_cycles(2);
        end
        chk("windows_after_table", 32'(windows), 5);
        chk("no_err_at_edge", 32'(timeout_err), 0);

        // Dead receiver.
        resp_lat = 0;
        resp_on = 1'b0;
        vcount = windows;
        enable = 1'b1;
        n = 0;
        while (!rx_en && n < 50) begin cyc(); n++; end
        n = 0;
        while (rx_en && n < 100) begin cyc(); n++; end
        chk("dead_rx_en_cycles", 32'(n), 32'(TOUT));
        chk("dead_err_set", 32'(timeout_err), 1);
        chk("dead_no_valid", 32'(windows), 32'(vcount));
        resp_on = 1'b1;
        queue_model(12'h0A0, N, 1'b1);
        wait_done("revive", 800);
        chk("err_sticky", 32'(timeout_err), 1);
        enable = 1'b0;
        idle_cycles(2);

        // Spurious strobes outside REQUEST must be ignored.
        spur_on = 1'b1;
        queue_model(12'h100, N, 1'b1);
        enable = 1'b1;
        wait_done("spurious", 800);
        spur_on = 1'b0;
        enable = 1'b0;
        idle_cycles(2);

        // Abort after 10 samples; the next window must hold only new samples.
        queue_model(12'hFFF, 10, 1'b0);
        enable = 1'b1;
        n = 0;
        while (samp_q.size() != 0 && n < 500) begin cyc(); n++; end
        idle_cycles(2);
        enable = 1'b0;
        idle_cycles(3);
        vcount = windows;
        chk("abort_no_valid", 32'(windows), 32'(vcount));
        queue_model(12'h200, N, 1'b1);
        enable = 1'b1;
        wait_done("abort", 800);

        // Reset in the middle of a request.
        resp_on = 1'b0;
        n = 0;
        while (!rx_en && n < 50) begin cyc(); n++; end
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_rx_en", 32'(rx_en), 0);
        chk("midrst_avg", 32'(avg_out), 0);
        chk("midrst_min", 32'(min_out), 0);
        chk("midrst_max", 32'(max_out), 0);
        chk("midrst_err", 32'(timeout_err), 0);
        @(negedge clk_nexys);
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk_nexys);
            #1;
            n++;
        end while (!rx_en && n < 50);
        chk("first_request_delay", 32'(n), 32'(SDIV + 1));
        enable = 1'b0;
        resp_on = 1'b1;
        idle_cycles(3);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
